// File: rtl/y86_pkg.sv
// y86_pkg: shared encodings for the Y86-64 pipeline.
//   - instruction codes (icode), status codes (stat), the "no register" id
//   - the run/halt state type used by the pipeline control unit
// The pipeline registers import the same package so every stage agrees on
// these encodings.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register id meaning "no register"
  localparam logic [3:0] R_NONE   = 4'hF;

  // Status codes
  localparam logic [1:0] S_AOK    = 2'd0;
  localparam logic [1:0] S_HLT    = 2'd1;
  localparam logic [1:0] S_ADR    = 2'd2;
  localparam logic [1:0] S_INS    = 2'd3;

  // Run/halt control state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/y86_hazard_detect.sv
// y86_hazard_detect: purely combinational hazard classification.
// Inputs : D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_Cnd,
//          m_stat, W_stat (pipeline register / stage values)
// Outputs: loaduse - load in E writes a register that D is reading
//          retp    - a ret is somewhere in D, E or M
//          mispred - conditional jump in E was predicted taken but is not
//          exc_m   - memory stage reports a non-AOK status
//          exc_w   - writeback register holds a non-AOK status
module y86_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] M_icode,
  input  logic [3:0] E_dstM,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic       e_Cnd,
  input  logic [1:0] m_stat,
  input  logic [1:0] W_stat,
  output logic       loaduse,
  output logic       retp,
  output logic       mispred,
  output logic       exc_m,
  output logic       exc_w
);

  logic e_is_load;

  assign e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);

  // RNONE guard matters: an unused source field is also encoded as RNONE,
  // so without it a load with no destination would match an absent source.
  assign loaduse = e_is_load && (E_dstM != R_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));

  assign retp    = (D_icode == I_RET) || (E_icode == I_RET) ||
                   (M_icode == I_RET);

  // Jumps are predicted taken, so a false condition is a mispredict.
  assign mispred = (E_icode == I_JXX) && !e_Cnd;

  assign exc_m   = (m_stat != S_AOK);
  assign exc_w   = (W_stat != S_AOK);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the Y86-64 five-stage pipeline.
// Parameters: CNT_W - width of each saturating performance counter.
// Inputs : clk, rst (async, active high), start (sampled in IDLE only),
//          D/E/M icodes, E_dstM, d_srcA/d_srcB, e_Cnd, m_stat, W_stat.
// Outputs: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
//          set_cc (pipeline register / condition code controls),
//          cpu_halted, final_stat (status that caused the halt),
//          cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt (RUN-only counters).
// Control outputs are combinational from inputs and current state so the
// pipeline registers act on them at the same clock edge.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_Cnd,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             cpu_halted,
  output logic [1:0]       final_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_state_e state_q, state_d;
  logic loaduse, retp, mispred, exc_m, exc_w;

  y86_hazard_detect u_hazard (
    .D_icode (D_icode),
    .E_icode (E_icode),
    .M_icode (M_icode),
    .E_dstM  (E_dstM),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .e_Cnd   (e_Cnd),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .loaduse (loaduse),
    .retp    (retp),
    .mispred (mispred),
    .exc_m   (exc_m),
    .exc_w   (exc_w)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and control outputs. Defaults are the frozen-pipeline
  // values used in IDLE and HALT: everything stalls, E/M flush to NOP.
  always_comb begin
    state_d  = state_q;
    F_stall  = 1'b1;
    D_stall  = 1'b1;
    D_bubble = 1'b0;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b1;
    set_cc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        F_stall  = loaduse | retp;
        D_stall  = loaduse;
        // Stall wins over bubble in D, so a ret waiting behind a load-use
        // stall is held rather than replaced.
        D_bubble = mispred | (retp & !loaduse);
        E_bubble = mispred | loaduse;
        M_bubble = exc_m | exc_w;
        W_stall  = exc_w;
        set_cc   = (E_icode == I_OPQ) & !exc_m & !exc_w;
        if (exc_w) state_d = ST_HALT;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cpu_halted = (state_q == ST_HALT);

  // Status of the instruction that stopped the machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      final_stat <= S_AOK;
    end else if (state_q == ST_RUN && exc_w) begin
      final_stat <= W_stat;
    end
  end

  // Saturating performance counters, active only in RUN (the cycle that
  // moves RUN to HALT is still counted).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      loaduse_cnt <= '0;
      mispred_cnt <= '0;
      ret_cnt     <= '0;
    end else if (state_q == ST_RUN) begin
      if (cycle_cnt != CNT_MAX)
        cycle_cnt <= cycle_cnt + CNT_ONE;
      if (loaduse && loaduse_cnt != CNT_MAX)
        loaduse_cnt <= loaduse_cnt + CNT_ONE;
      if (mispred && mispred_cnt != CNT_MAX)
        mispred_cnt <= mispred_cnt + CNT_ONE;
      if (retp && !loaduse && ret_cnt != CNT_MAX)
        ret_cnt <= ret_cnt + CNT_ONE;
    end
  end

endmodule
